exu_lsu: RTL and testbench

Load/store unit sitting directly downstream of the address-generation stage in the execute unit. It accepts one aligned memory request per handshake, runs a single-outstanding transaction on a request/grant data bus, and returns the load result (lane-extracted and sign/zero-extended) or a store completion. Store byte-lane replication and a response timeout are handled here; misalignment is already filtered upstream.

---
 rtl/exu_lsu_if.sv | 38 +++
 rtl/exu_lsu.sv | 178 +++++++++++++++++
 tb/tb_exu_lsu.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/exu_lsu_if.sv
// AGU-side request/response handshake plus the request/grant data bus of the LSU.
// The slave view is the LSU itself; the master view is everything around it.
interface exu_lsu_if;
    logic        hs_ag4ls_val;
    logic        hs_ls4ag_rdy;
    logic [31:0] i_ls_adr;
    logic [31:0] i_ls_wdat;
    logic [3:0]  i_ls_wen;
    logic        i_ls_ren;
    logic [1:0]  i_ls_size;
    logic        i_ls_unsigned;
    logic [31:0] o_ls_rdat;
    logic        o_ls_done;
    logic        o_ls_err;
    logic        o_bus_req;
    logic        i_bus_gnt;
    logic [31:0] o_bus_adr;
    logic        o_bus_we;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdat;
    logic        i_bus_rvld;
    logic [31:0] i_bus_rdat;
    logic        i_bus_err;

    modport slave (
        input  hs_ag4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren, i_ls_size, i_ls_unsigned,
        input  i_bus_gnt, i_bus_rvld, i_bus_rdat, i_bus_err,
        output hs_ls4ag_rdy, o_ls_rdat, o_ls_done, o_ls_err,
        output o_bus_req, o_bus_adr, o_bus_we, o_bus_be, o_bus_wdat
    );

    modport master (
        output hs_ag4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren, i_ls_size, i_ls_unsigned,
        output i_bus_gnt, i_bus_rvld, i_bus_rdat, i_bus_err,
        input  hs_ls4ag_rdy, o_ls_rdat, o_ls_done, o_ls_err,
        input  o_bus_req, o_bus_adr, o_bus_we, o_bus_be, o_bus_wdat
    );
endinterface

// File: rtl/exu_lsu.sv
// Single-outstanding load/store unit: one aligned request per handshake, bus request/grant,
// lane-extracted load return or store completion, with an optional response timeout.
module exu_lsu #(
    parameter int TMO_CYC = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    exu_lsu_if.slave  ls
);
    localparam int CW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam logic [CW-1:0] TMO_V = CW'(TMO_CYC);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    adr_lo_q, adr_lo_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic [31:0]   bus_adr_q, bus_adr_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [CW-1:0] cnt_inc;
    logic          tmo_hit;
    logic [31:0]   shft;
    logic [31:0]   ext;
    logic [3:0]    ld_be;
    logic [31:0]   rep;

    assign ls.hs_ls4ag_rdy = (state_q == IDLE);
    assign ls.o_bus_req    = req_q;
    assign ls.o_bus_adr    = bus_adr_q;
    assign ls.o_bus_we     = we_q;
    assign ls.o_bus_be     = be_q;
    assign ls.o_bus_wdat   = wdat_q;
    assign ls.o_ls_rdat    = rdat_q;
    assign ls.o_ls_done    = done_q;
    assign ls.o_ls_err     = err_q;

    assign cnt_inc = cnt_q + CW'(1);
    assign tmo_hit = (TMO_CYC > 0) && (cnt_inc == TMO_V);

    // Lane selection and replication are computed from the incoming request at accept time.
    always_comb begin
        ld_be = 4'hF;
        rep   = ls.i_ls_wdat;
        case (ls.i_ls_size)
            2'b00: begin
                ld_be = 4'b0001 << ls.i_ls_adr[1:0];
                rep   = {4{ls.i_ls_wdat[7:0]}};
            end
            2'b01: begin
                ld_be = ls.i_ls_adr[1] ? 4'b1100 : 4'b0011;
                rep   = {2{ls.i_ls_wdat[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shft = ls.i_bus_rdat >> {adr_lo_q, 3'b000};
        case (size_q)
            2'b00:   ext = {{24{~uns_q & shft[7]}}, shft[7:0]};
            2'b01:   ext = {{16{~uns_q & shft[15]}}, shft[15:0]};
            default: ext = ls.i_bus_rdat;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        adr_lo_d  = adr_lo_q;
        size_d    = size_q;
        uns_d     = uns_q;
        st_d      = st_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        bus_adr_d = bus_adr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (ls.hs_ag4ls_val) begin
                adr_lo_d = ls.i_ls_adr[1:0];
                size_d   = ls.i_ls_size;
                uns_d    = ls.i_ls_unsigned;
                st_d     = |ls.i_ls_wen;
                cnt_d    = '0;
                if ((|ls.i_ls_wen) || ls.i_ls_ren) begin
                    state_d   = REQ;
                    req_d     = 1'b1;
                    bus_adr_d = {ls.i_ls_adr[31:2], 2'b00};
                    we_d      = |ls.i_ls_wen;
                    be_d      = (|ls.i_ls_wen) ? ls.i_ls_wen : ld_be;
                    wdat_d    = rep;
                end else begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    rdat_d  = '0;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (tmo_hit) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    rdat_d  = '0;
                    err_d   = 1'b1;
                end else if (ls.i_bus_gnt) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // A response landing on the timeout cycle still counts as in time.
                if (ls.i_bus_rvld) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = ls.i_bus_err;
                    rdat_d  = (ls.i_bus_err || st_q) ? 32'h0 : ext;
                end else if (tmo_hit) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    rdat_d  = '0;
                    err_d   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            adr_lo_q  <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            st_q      <= 1'b0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            bus_adr_q <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_lo_q  <= adr_lo_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            bus_adr_q <= bus_adr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_exu_lsu.sv
// Directed plus randomized bench for exu_lsu; expected values come from an arithmetic
// model of the lane/extension rules, and a second instance exercises the timeout.
module tb_exu_lsu;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    exu_lsu_if ifa();
    exu_lsu_if ifb();

    exu_lsu #(.TMO_CYC(255)) dut_a (.clk(clk), .rst_n(rst_n), .ls(ifa.slave));
    exu_lsu #(.TMO_CYC(4))   dut_b (.clk(clk), .rst_n(rst_n), .ls(ifb.slave));

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] adr, input logic [1:0] size,
                                        input logic [3:0] wen);
        int nb = nbytes(size);
        int off = int'(adr % 4);
        if (wen != 0) return wen;
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdat(input logic [31:0] wdat, input logic [1:0] size);
        int nb = nbytes(size);
        longint unit = longint'(wdat) % (longint'(1) << (8 * nb));
        longint acc = 0;
        for (int k = 0; k < 4 / nb; k++) acc = acc + (unit << (8 * nb * k));
        return 32'(acc);
    endfunction

    function automatic logic [31:0] m_ld(input logic [31:0] rdat, input logic [31:0] adr,
                                         input logic [1:0] size, input logic uns);
        int nb = nbytes(size);
        int off = int'(adr % 4);
        longint span = longint'(1) << (8 * nb);
        longint v = (longint'(rdat) >> (8 * off)) % span;
        if (!uns && nb < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic txn(input string tag, input logic [31:0] adr, input logic [31:0] wdat,
                       input logic [3:0] wen, input logic ren, input logic [1:0] size,
                       input logic uns, input int gd, input int rd,
                       input logic [31:0] brdat, input logic berr, input bit junk);
        bit st = (wen != 0);
        chk({tag, ".rdy"}, 32'(ifa.hs_ls4ag_rdy), 32'd1);
        ifa.hs_ag4ls_val = 1'b1;
        ifa.i_ls_adr = adr; ifa.i_ls_wdat = wdat; ifa.i_ls_wen = wen;
        ifa.i_ls_ren = ren; ifa.i_ls_size = size; ifa.i_ls_unsigned = uns;
        tick();
        ifa.hs_ag4ls_val = 1'b0;
        if (!st && !ren) begin
            chk({tag, ".noop_req"}, 32'(ifa.o_bus_req), 32'd0);
            chk({tag, ".noop_done"}, 32'(ifa.o_ls_done), 32'd1);
            chk({tag, ".noop_rdat"}, ifa.o_ls_rdat, 32'd0);
            chk({tag, ".noop_err"}, 32'(ifa.o_ls_err), 32'd0);
            tick();
            chk({tag, ".noop_done_end"}, 32'(ifa.o_ls_done), 32'd0);
            return;
        end
        chk({tag, ".req"}, 32'(ifa.o_bus_req), 32'd1);
        chk({tag, ".adr"}, ifa.o_bus_adr, {adr[31:2], 2'b00});
        chk({tag, ".we"}, 32'(ifa.o_bus_we), 32'(st));
        chk({tag, ".be"}, 32'(ifa.o_bus_be), 32'(m_be(adr, size, wen)));
        if (st) chk({tag, ".wdat"}, ifa.o_bus_wdat, m_wdat(wdat, size));
        for (int i = 0; i < gd; i++) tick();
        if (gd > 0) begin
            chk({tag, ".req_held"}, 32'(ifa.o_bus_req), 32'd1);
            chk({tag, ".adr_held"}, ifa.o_bus_adr, {adr[31:2], 2'b00});
            if (st) chk({tag, ".wdat_held"}, ifa.o_bus_wdat, m_wdat(wdat, size));
        end
        ifa.i_bus_gnt = 1'b1;
        if (junk) begin
            ifa.i_bus_rvld = 1'b1; ifa.i_bus_rdat = ~brdat; ifa.i_bus_err = 1'b1;
        end
        tick();
        ifa.i_bus_gnt = 1'b0; ifa.i_bus_rvld = 1'b0; ifa.i_bus_err = 1'b0;
        chk({tag, ".req_drop"}, 32'(ifa.o_bus_req), 32'd0);
        chk({tag, ".early_done"}, 32'(ifa.o_ls_done), 32'd0);
        for (int i = 0; i < rd; i++) tick();
        ifa.i_bus_rvld = 1'b1; ifa.i_bus_rdat = brdat; ifa.i_bus_err = berr;
        tick();
        ifa.i_bus_rvld = 1'b0; ifa.i_bus_err = 1'b0;
        chk({tag, ".done"}, 32'(ifa.o_ls_done), 32'd1);
        chk({tag, ".err"}, 32'(ifa.o_ls_err), 32'(berr));
        if (!st) chk({tag, ".rdat"}, ifa.o_ls_rdat, berr ? 32'd0 : m_ld(brdat, adr, size, uns));
        tick();
        chk({tag, ".done_end"}, 32'(ifa.o_ls_done), 32'd0);
        chk({tag, ".rdy_end"}, 32'(ifa.hs_ls4ag_rdy), 32'd1);
    endtask

    initial begin
        logic [31:0] adr;
        logic [1:0]  size;
        logic [3:0]  wen;
        logic        st;
        rst_n = 1'b0;
        ifa.hs_ag4ls_val = 0; ifa.i_ls_adr = 0; ifa.i_ls_wdat = 0; ifa.i_ls_wen = 0;
        ifa.i_ls_ren = 0; ifa.i_ls_size = 0; ifa.i_ls_unsigned = 0;
        ifa.i_bus_gnt = 0; ifa.i_bus_rvld = 0; ifa.i_bus_rdat = 0; ifa.i_bus_err = 0;
        ifb.hs_ag4ls_val = 0; ifb.i_ls_adr = 0; ifb.i_ls_wdat = 0; ifb.i_ls_wen = 0;
        ifb.i_ls_ren = 0; ifb.i_ls_size = 0; ifb.i_ls_unsigned = 0;
        ifb.i_bus_gnt = 0; ifb.i_bus_rvld = 0; ifb.i_bus_rdat = 0; ifb.i_bus_err = 0;
        tick();
        chk("rst.rdy", 32'(ifa.hs_ls4ag_rdy), 32'd1);
        chk("rst.req", 32'(ifa.o_bus_req), 32'd0);
        chk("rst.be", 32'(ifa.o_bus_be), 32'd0);
        chk("rst.done", 32'(ifa.o_ls_done), 32'd0);
        chk("rst.rdat", ifa.o_ls_rdat, 32'd0);
        rst_n = 1'b1;
        tick();

        txn("lb",  32'h103, 0, 4'b0000, 1, 2'd0, 0, 0, 0, 32'h80112233, 0, 0);
        txn("lbu", 32'h103, 0, 4'b0000, 1, 2'd0, 1, 0, 0, 32'h80112233, 0, 0);
        chk("lb.be_lit", 32'(ifa.o_bus_be), 32'h8);
        txn("sh",  32'h202, 32'h0000ABCD, 4'b1100, 0, 2'd1, 0, 5, 0, 0, 0, 0);
        chk("sh.wdat_lit", ifa.o_bus_wdat, 32'hABCDABCD);
        txn("lw_err", 32'h300, 0, 4'b0000, 1, 2'd2, 0, 0, 1, 32'h12345678, 1, 0);
        txn("noop", 32'h44, 32'h55, 4'b0000, 0, 2'd2, 0, 0, 0, 0, 0, 0);
        txn("gnt_rvld_same", 32'h8, 0, 4'b0000, 1, 2'd2, 0, 1, 2, 32'hCAFEF00D, 0, 1);
        txn("st_and_ld", 32'h10, 32'h000000A5, 4'b0010, 1, 2'd0, 0, 0, 0, 0, 0, 0);

        // Timeout path: grant never arrives.
        ifb.hs_ag4ls_val = 1'b1; ifb.i_ls_adr = 32'h40; ifb.i_ls_ren = 1'b1; ifb.i_ls_size = 2'd2;
        tick();
        ifb.hs_ag4ls_val = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tmo.req%0d", i), 32'(ifb.o_bus_req), 32'd1);
            chk($sformatf("tmo.nodone%0d", i), 32'(ifb.o_ls_done), 32'd0);
            tick();
        end
        chk("tmo.done", 32'(ifb.o_ls_done), 32'd1);
        chk("tmo.err", 32'(ifb.o_ls_err), 32'd1);
        chk("tmo.rdat", ifb.o_ls_rdat, 32'd0);
        chk("tmo.req_drop", 32'(ifb.o_bus_req), 32'd0);
        tick();
        ifb.i_bus_rvld = 1'b1; ifb.i_bus_rdat = 32'hDEADBEEF;
        tick();
        ifb.i_bus_rvld = 1'b0;
        chk("tmo.late_rvld", 32'(ifb.o_ls_done), 32'd0);
        chk("tmo.rdy", 32'(ifb.hs_ls4ag_rdy), 32'd1);

        // Reset while a load waits for its response.
        ifa.hs_ag4ls_val = 1'b1; ifa.i_ls_adr = 32'h5554; ifa.i_ls_wen = 0;
        ifa.i_ls_ren = 1'b1; ifa.i_ls_size = 2'd2;
        tick();
        ifa.hs_ag4ls_val = 1'b0; ifa.i_bus_gnt = 1'b1;
        tick();
        ifa.i_bus_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.rdy", 32'(ifa.hs_ls4ag_rdy), 32'd1);
        chk("mid_rst.req", 32'(ifa.o_bus_req), 32'd0);
        chk("mid_rst.adr", ifa.o_bus_adr, 32'd0);
        chk("mid_rst.we_be", {27'd0, ifa.o_bus_we, ifa.o_bus_be}, 32'd0);
        chk("mid_rst.wdat", ifa.o_bus_wdat, 32'd0);
        chk("mid_rst.done_err", {30'd0, ifa.o_ls_done, ifa.o_ls_err}, 32'd0);
        chk("mid_rst.rdat", ifa.o_ls_rdat, 32'd0);
        tick();
        rst_n = 1'b1;
        ifa.i_bus_rvld = 1'b1; ifa.i_bus_rdat = 32'h11111111;
        tick();
        ifa.i_bus_rvld = 1'b0;
        tick();
        chk("mid_rst.nodone", 32'(ifa.o_ls_done), 32'd0);
        txn("lh_post_rst", 32'h2, 0, 4'b0000, 1, 2'd1, 0, 0, 0, 32'h7FFF0000, 0, 0);

        for (int i = 0; i < 40; i++) begin
            size = 2'($urandom_range(0, 3));
            adr  = $urandom;
            if (size == 2'd1) adr[0] = 1'b0;
            if (size >= 2'd2) adr[1:0] = 2'b00;
            st  = 1'($urandom_range(0, 1));
            wen = st ? 4'($urandom_range(1, 15)) : 4'd0;
            txn($sformatf("rnd%0d", i), adr, $urandom, wen,
                st ? 1'($urandom_range(0, 1)) : 1'b1, size, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
